// File: rtl/fix_add_arbiter.sv
// fix_add_arbiter
//
// Round-robin scheduler sharing one fixed-point adder (WIDTH1.WIDTH2,
// two's complement) among NREQ requesters. One operand pair is accepted
// per cycle, issued to the adder through registered outputs, and the
// requester tag travels alongside the adder latency so the result comes
// back on a single tagged response bus, optionally saturated on overflow.
//
// Handshake: requester i transfers an operand pair in the cycle where
// req_vld[i] & req_rdy[i] is high. req_rdy is combinational, at most one
// bit is set, and it never depends on anything the requester does in
// response to it. A requester keeps req_vld/req_a/req_b stable until it
// is granted; dropping req_vld before the grant withdraws the request.
// The response side has no backpressure: rsp_vld is a one-cycle strobe.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   hold                suppress new grants this cycle
//   req_vld/req_a/req_b per-requester operand valid and packed operands
//   req_rdy             one-hot grant
//   add_vld_in/add_a/b  registered issue to the adder
//   add_r/add_vld_out/add_ovf  adder result, valid, overflow
//   rsp_vld/rsp_id/rsp_r/rsp_ovf  tagged response
//   ovf_sticky/ovf_clr  per-requester overflow sticky bits and clears
//   tag_err             sticky: adder result and tag pipeline disagreed
module fix_add_arbiter #(
  parameter int WIDTH1  = 9,
  parameter int WIDTH2  = 7,
  parameter int WIDTH   = WIDTH1 + WIDTH2,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ADD_LAT = 1,
  parameter int SAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_rdy,
  output logic                  add_vld_in,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_r,
  input  logic                  add_vld_out,
  input  logic                  add_ovf,
  output logic                  rsp_vld,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_r,
  output logic                  rsp_ovf,
  output logic [NREQ-1:0]       ovf_sticky,
  input  logic [NREQ-1:0]       ovf_clr,
  output logic                  tag_err
);

  // Elaboration-time sanity of the parameter set.
  if (WIDTH != WIDTH1 + WIDTH2) begin : g_bad_width
    $error("fix_add_arbiter: WIDTH must equal WIDTH1+WIDTH2");
  end
  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ) begin : g_bad_nreq
    $error("fix_add_arbiter: NREQ must be 2..8 and fit in IDW bits");
  end
  if (ADD_LAT < 1 || ADD_LAT > 4) begin : g_bad_lat
    $error("fix_add_arbiter: ADD_LAT must be 1..4");
  end

  // ---------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------
  logic [IDW-1:0]    ptr;
  logic [2*NREQ-1:0] vld_rot2;
  logic [NREQ-1:0]   vld_rot;
  logic [IDW-1:0]    off;
  logic [IDW:0]      id_sum;
  logic              gnt_any;
  logic [IDW-1:0]    gnt_id;
  logic [IDW-1:0]    ptr_nxt;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;

  always_comb begin
    // Rotate the request vector so the pointer position lands at bit 0;
    // the lowest set bit of the rotated vector is then the winner.
    vld_rot2 = {req_vld, req_vld} >> ptr;
    vld_rot  = vld_rot2[NREQ-1:0];
    gnt_any  = 1'b0;
    off      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (vld_rot[k]) begin
        gnt_any = 1'b1;
        off     = IDW'(k);
      end
    end
    if (hold || rst) gnt_any = 1'b0;

    // Undo the rotation: winner = (ptr + off) mod NREQ.
    id_sum = {1'b0, ptr} + {1'b0, off};
    if (id_sum >= (IDW+1)'(NREQ)) gnt_id = IDW'(id_sum - (IDW+1)'(NREQ));
    else                          gnt_id = id_sum[IDW-1:0];

    ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

    req_rdy = '0;
    if (gnt_any) req_rdy[gnt_id] = 1'b1;

    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------
  // Pointer and issue register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      add_vld_in <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
    end else begin
      add_vld_in <= gnt_any;
      if (gnt_any) begin
        ptr   <= ptr_nxt;
        add_a <= sel_a;
        add_b <= sel_b;
      end
    end
  end

  // ---------------------------------------------------------------
  // Tag pipeline: entry k describes the issue made k+1 cycles ago, so
  // entry ADD_LAT lines up with add_vld_out. tag_known marks slots
  // filled after the last reset; results landing in older slots belong
  // to abandoned operations and are ignored without raising tag_err.
  // ---------------------------------------------------------------
  logic [ADD_LAT:0] tag_vld;
  logic [ADD_LAT:0] tag_sign;
  logic [ADD_LAT:0] tag_known;
  logic [IDW-1:0]   tag_id [ADD_LAT+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld   <= '0;
      tag_sign  <= '0;
      tag_known <= '0;
      for (int k = 0; k <= ADD_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld   <= {tag_vld[ADD_LAT-1:0], gnt_any};
      tag_sign  <= {tag_sign[ADD_LAT-1:0], sel_a[WIDTH-1]};
      tag_known <= {tag_known[ADD_LAT-1:0], 1'b1};
      tag_id[0] <= gnt_id;
      for (int k = 1; k <= ADD_LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  logic           tail_vld;
  logic           tail_sign;
  logic           tail_known;
  logic [IDW-1:0] tail_id;

  assign tail_vld   = tag_vld[ADD_LAT];
  assign tail_sign  = tag_sign[ADD_LAT];
  assign tail_known = tag_known[ADD_LAT];
  assign tail_id    = tag_id[ADD_LAT];

  // ---------------------------------------------------------------
  // Response register, overflow sticky and tag error
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] rsp_r_nxt;
  logic [NREQ-1:0]  sticky_set;
  logic             rsp_fire;
  logic             tag_fault;

  always_comb begin
    rsp_fire  = add_vld_out && tail_vld;
    rsp_r_nxt = add_r;
    // On overflow both operands share a sign, so operand A's sign picks
    // the saturation direction.
    if (SAT != 0 && add_ovf) begin
      rsp_r_nxt = tail_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    sticky_set = '0;
    if (rsp_fire && add_ovf) sticky_set[tail_id] = 1'b1;
    tag_fault = (add_vld_out && !tail_vld && tail_known) || (tail_vld && !add_vld_out);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld    <= 1'b0;
      rsp_id     <= '0;
      rsp_r      <= '0;
      rsp_ovf    <= 1'b0;
      ovf_sticky <= '0;
      tag_err    <= 1'b0;
    end else begin
      rsp_vld    <= rsp_fire;
      rsp_id     <= tail_id;
      rsp_r      <= rsp_r_nxt;
      rsp_ovf    <= add_ovf;
      // Set is applied after clear so a same-cycle set survives.
      ovf_sticky <= (ovf_sticky & ~ovf_clr) | sticky_set;
      if (tag_fault) tag_err <= 1'b1;
    end
  end

endmodule
